// File: rtl/des_round_controller.sv
// des_round_controller: control sequencer for an iterative single-round DES
// datapath. Issues load / round / final-permutation strobes, the round index
// and key-schedule rotation controls, and a valid/ready result handshake.
module des_round_controller #(
   parameter int NUM_ROUNDS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  logic       decrypt_i,
   output logic       load_o,
   output logic       round_en_o,
   output logic [4:0] round_o,
   output logic [1:0] shift_amt_o,
   output logic       shift_right_o,
   output logic       fp_en_o,
   output logic       busy_o,
   output logic       out_valid_o,
   input  logic       out_ready_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ROUND,
      S_FINAL,
      S_DONE
   } state_t;

   localparam logic [4:0] LP_LAST = 5'(NUM_ROUNDS);

   state_t     r_state;
   logic [4:0] r_cnt;
   logic       r_mode;
   logic       w_accept;

   // Key-schedule rotation per round. Decrypt rotates right and skips the
   // first rotation so C/D walk backwards from PC1(key) to the same end point.
   function automatic logic [1:0] f_shift(input logic [4:0] rnd, input logic dec);
      if (dec && rnd == 5'd1)
         return 2'd0;
      else if (rnd == 5'd1 || rnd == 5'd2 || rnd == 5'd9 || rnd == 5'd16)
         return 2'd1;
      else
         return 2'd2;
   endfunction

   // Ready in IDLE, or in DONE the same cycle the consumer drains the result.
   assign in_ready_o = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready_i);
   assign w_accept   = in_ready_o & in_valid_i;

   // Sequencer FSM; all strobes are registered from the next-state decision.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= 5'd0;
         r_mode        <= 1'b0;
         load_o        <= 1'b0;
         round_en_o    <= 1'b0;
         round_o       <= 5'd0;
         shift_amt_o   <= 2'd0;
         shift_right_o <= 1'b0;
         fp_en_o       <= 1'b0;
         busy_o        <= 1'b0;
         out_valid_o   <= 1'b0;
      end else begin
         load_o      <= 1'b0;
         round_en_o  <= 1'b0;
         round_o     <= 5'd0;
         shift_amt_o <= 2'd0;
         fp_en_o     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_mode        <= decrypt_i;
                  shift_right_o <= decrypt_i;
                  load_o        <= 1'b1;
                  busy_o        <= 1'b1;
                  r_state       <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_cnt       <= 5'd1;
               round_en_o  <= 1'b1;
               round_o     <= 5'd1;
               shift_amt_o <= f_shift(5'd1, r_mode);
               r_state     <= S_ROUND;
            end
            S_ROUND: begin
               if (r_cnt == LP_LAST) begin
                  r_cnt   <= 5'd0;
                  fp_en_o <= 1'b1;
                  r_state <= S_FINAL;
               end else begin
                  r_cnt       <= r_cnt + 5'd1;
                  round_en_o  <= 1'b1;
                  round_o     <= r_cnt + 5'd1;
                  shift_amt_o <= f_shift(r_cnt + 5'd1, r_mode);
               end
            end
            S_FINAL: begin
               out_valid_o <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready_i) begin
                  out_valid_o <= 1'b0;
                  if (in_valid_i) begin
                     // Back-to-back: skip IDLE and start the next block now.
                     r_mode        <= decrypt_i;
                     shift_right_o <= decrypt_i;
                     load_o        <= 1'b1;
                     r_state       <= S_LOAD;
                  end else begin
                     busy_o  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_des_round_controller.sv
// Directed bench for des_round_controller: full-length instance plus a
// 4-round instance, checked at the falling edge against hand-built schedules.
module tb_des_round_controller;

   logic       clk;
   logic       rst;
   logic       in_valid, in_ready, decrypt, load, round_en, sright, fp_en, busy, out_valid, out_ready;
   logic [4:0] round;
   logic [1:0] shamt;

   logic       in_valid4, in_ready4, decrypt4, load4, round_en4, sright4, fp_en4, busy4, out_valid4, out_ready4;
   logic [4:0] round4;
   logic [1:0] shamt4;

   int checks = 0;
   int errors = 0;

   int enc_sch [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
   int dec_sch [1:16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   des_round_controller #(.NUM_ROUNDS(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .decrypt_i(decrypt), .load_o(load), .round_en_o(round_en), .round_o(round),
      .shift_amt_o(shamt), .shift_right_o(sright), .fp_en_o(fp_en), .busy_o(busy),
      .out_valid_o(out_valid), .out_ready_i(out_ready)
   );

   des_round_controller #(.NUM_ROUNDS(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
      .decrypt_i(decrypt4), .load_o(load4), .round_en_o(round_en4), .round_o(round4),
      .shift_amt_o(shamt4), .shift_right_o(sright4), .fp_en_o(fp_en4), .busy_o(busy4),
      .out_valid_o(out_valid4), .out_ready_i(out_ready4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic exp_all(input string tag, input logic ld, input logic ren, input logic [4:0] rnd,
                          input logic [1:0] sa, input logic sr, input logic fp, input logic bs,
                          input logic ov, input logic ir);
      chk({tag, " load"}, 32'(load), 32'(ld));
      chk({tag, " round_en"}, 32'(round_en), 32'(ren));
      chk({tag, " round"}, 32'(round), 32'(rnd));
      chk({tag, " shamt"}, 32'(shamt), 32'(sa));
      chk({tag, " sright"}, 32'(sright), 32'(sr));
      chk({tag, " fp_en"}, 32'(fp_en), 32'(fp));
      chk({tag, " busy"}, 32'(busy), 32'(bs));
      chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
      chk({tag, " in_ready"}, 32'(in_ready), 32'(ir));
   endtask

   // One block from accept to DONE. pre: request already presented/accepted;
   // keep: leave in_valid asserted; tog: flip decrypt every cycle.
   task automatic run_block(input logic dec, input bit tog, input bit pre, input bit keep);
      logic [1:0] sa;
      if (!pre) begin
         in_valid = 1'b1;
         decrypt  = dec;
      end
      @(negedge clk);
      if (!keep) in_valid = 1'b0;
      if (tog) decrypt = ~decrypt;
      exp_all("load", 1, 0, 0, 0, dec, 0, 1, 0, 0);
      for (int r = 1; r <= 16; r++) begin
         @(negedge clk);
         if (tog) decrypt = ~decrypt;
         sa = dec ? 2'(dec_sch[r]) : 2'(enc_sch[r]);
         exp_all($sformatf("round%0d", r), 0, 1, 5'(r), sa, dec, 0, 1, 0, 0);
      end
      @(negedge clk);
      exp_all("final", 0, 0, 0, 0, dec, 1, 1, 0, 0);
      @(negedge clk);
      exp_all("done", 0, 0, 0, 0, dec, 0, 1, 1, out_ready);
   endtask

   // Strobes are mutually exclusive on both instances at every sample point.
   always @(negedge clk) begin
      checks++;
      assert ($onehot0({load, round_en, fp_en}) && $onehot0({load4, round_en4, fp_en4})) else begin
         errors++;
         $error("FAIL strobe_excl observed %b/%b expected onehot0",
                {load, round_en, fp_en}, {load4, round_en4, fp_en4});
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; decrypt = 1'b0; out_ready = 1'b1;
      in_valid4 = 1'b0; decrypt4 = 1'b0; out_ready4 = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("reset4 in_ready", 32'(in_ready4), 1);
      chk("reset4 busy", 32'(busy4), 0);

      // single encrypt, then idle
      run_block(0, 0, 0, 0);
      @(negedge clk);
      exp_all("enc idle", 0, 0, 0, 0, 0, 0, 0, 0, 1);

      // single decrypt
      run_block(1, 0, 0, 0);
      @(negedge clk);
      exp_all("dec idle", 0, 0, 0, 0, 1, 0, 0, 0, 1);

      // decrypt_i toggling mid-block must not disturb the encrypt schedule
      run_block(0, 1, 0, 0);
      decrypt = 1'b0;
      @(negedge clk);
      exp_all("tog idle", 0, 0, 0, 0, 0, 0, 0, 0, 1);

      // backpressure for 10 cycles, then same-cycle accept and back-to-back
      out_ready = 1'b0;
      run_block(0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         exp_all("bp hold", 0, 0, 0, 0, 0, 0, 1, 1, 0);
      end
      decrypt = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      #1;
      chk("bp release in_ready", 32'(in_ready), 1);
      run_block(1, 0, 1, 1);
      decrypt = 1'b0;
      run_block(0, 0, 1, 0);
      @(negedge clk);
      exp_all("b2b idle", 0, 0, 0, 0, 0, 0, 0, 0, 1);

      // reset while holding a result in DONE
      out_ready = 1'b0;
      run_block(1, 0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      exp_all("rst in done", 0, 0, 0, 0, 0, 0, 0, 0, 1);

      // reset at round 7, then a normal block
      in_valid = 1'b1; decrypt = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      chk("mid round index", 32'(round), 7);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_all("rst mid round", 0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post rst fp_en", 32'(fp_en), 0);
         chk("post rst busy", 32'(busy), 0);
      end
      run_block(0, 0, 0, 0);
      @(negedge clk);
      exp_all("post rst idle", 0, 0, 0, 0, 0, 0, 0, 0, 1);

      // reduced-round instance: accept at 0, rounds 2..5, fp 6, valid 7
      in_valid4 = 1'b1;
      @(negedge clk);
      in_valid4 = 1'b0;
      chk("r4 c1 load", 32'(load4), 1);
      for (int c = 2; c <= 7; c++) begin
         @(negedge clk);
         chk($sformatf("r4 c%0d round_en", c), 32'(round_en4), (c >= 2 && c <= 5) ? 1 : 0);
         chk($sformatf("r4 c%0d round", c), 32'(round4), (c <= 5) ? c - 1 : 0);
         chk($sformatf("r4 c%0d shamt", c), 32'(shamt4), (c <= 5) ? enc_sch[c - 1] : 0);
         chk($sformatf("r4 c%0d fp_en", c), 32'(fp_en4), (c == 6) ? 1 : 0);
         chk($sformatf("r4 c%0d out_valid", c), 32'(out_valid4), (c == 7) ? 1 : 0);
      end
      @(negedge clk);
      chk("r4 idle busy", 32'(busy4), 0);
      chk("r4 idle in_ready", 32'(in_ready4), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/des_round_controller.md
# des_round_controller

Sequencer for the iterative DES core: accepts one 64-bit block request per handshake, drives the load, round-enable, key-shift and final-permutation controls of a single-round datapath (IP permutation, one Feistel round, key-schedule registers, FP permutation), and returns a done handshake. It holds no data; it only issues control strobes and the round index to the datapath and key schedule.

## Interface

- NUM_ROUNDS, 16, number of Feistel rounds executed per block; legal range 1..16 (values below 16 are for reduced-round experiments)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid_i  input  1  requester has a block and key on the datapath inputs
- in_ready_o  output  1  controller accepts a request this cycle
- decrypt_i  input  1  mode for the request; sampled only on accept (1 = decrypt)
- load_o  output  1  datapath captures IP(block) into L/R and PC1(key) into C/D
- round_en_o  output  1  datapath executes one round and key registers shift this cycle
- round_o  output  5  current round index, 1..NUM_ROUNDS while round_en_o=1, else 0
- shift_amt_o  output  2  C/D rotation amount for this round: 0, 1 or 2
- shift_right_o  output  1  rotation direction: 0 = left (encrypt), 1 = right (decrypt)
- fp_en_o  output  1  output register captures FP(R16 || L16)
- busy_o  output  1  a block is in flight (any state other than IDLE)
- out_valid_o  output  1  result in output register is valid
- out_ready_i  input  1  consumer takes the result

## Operation

- States: IDLE, LOAD, ROUND, FINAL, DONE; all outputs registered except in_ready_o.
- IDLE: in_ready_o=1. in_valid_i=1 -> latch decrypt_i into mode register, go LOAD.
- LOAD (1 cycle): load_o=1; round counter set to 1; go ROUND.
- ROUND (NUM_ROUNDS cycles): round_en_o=1, round_o=counter; counter increments each cycle; at counter=NUM_ROUNDS go FINAL.
- FINAL (1 cycle): fp_en_o=1; go DONE.
- DONE: out_valid_o=1 held until out_ready_i=1. On out_ready_i=1: if in_valid_i=1 accept new request directly (latch decrypt_i, go LOAD), else go IDLE.
- in_ready_o = (state==IDLE) | (state==DONE & out_ready_i); combinational path out_ready_i -> in_ready_o permitted.
- Shift schedule, encrypt (shift_right_o=0): shift_amt_o=1 for rounds 1, 2, 9, 16; 2 otherwise.
- Shift schedule, decrypt (shift_right_o=1): shift_amt_o=0 for round 1; 1 for rounds 2, 9, 16; 2 otherwise.
- Outside ROUND: shift_amt_o=0, shift_right_o=latched mode, round_o=0.
- Mode register changes only on accept; decrypt_i toggling mid-block has no effect.
- in_valid_i while busy (not IDLE/DONE-accept) is ignored; requester must hold it until in_ready_o.
- Exactly one of load_o, round_en_o, fp_en_o high in any cycle, or none.

## Timing

- Reset: state=IDLE, counter=0, mode=0; outputs load_o=0, round_en_o=0, round_o=0, shift_amt_o=0, shift_right_o=0, fp_en_o=0, busy_o=0, out_valid_o=0; in_ready_o=1 in the first cycle after reset.
- Accept at cycle 0 -> load_o cycle 1 -> round_en_o cycles 2..NUM_ROUNDS+1 -> fp_en_o cycle NUM_ROUNDS+2 -> out_valid_o from cycle NUM_ROUNDS+3 (19 for 16 rounds).
- Back-to-back with out_ready_i=1 tied high: one block per NUM_ROUNDS+3 cycles (no IDLE cycle).
- rst asserted in any state, including mid-ROUND or in DONE with out_valid_o=1: next cycle IDLE with reset values; in-flight block discarded, no fp_en_o issued.
- Counter width 5 bits; never exceeds NUM_ROUNDS, no wrap.

## Test plan

- Reset then single encrypt, out_ready_i=1: in_valid_i pulse at cycle 0 -> load_o cycle 1, round_en_o cycles 2..17 with round_o 1..16 and shift_amt_o 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 left, fp_en_o cycle 18, out_valid_o cycle 19; datapath with key 133457799BBCDFF1, plaintext 0123456789ABCDEF yields 85E813540F0AB405.
- Single decrypt of 85E813540F0AB405 with same key -> shift_amt_o 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 right; result 0123456789ABCDEF; C/D registers equal PC1(key) after round 16 in both modes.
- Backpressure: out_ready_i=0 for 10 cycles after out_valid_o -> out_valid_o held, in_ready_o=0, no strobes; release with in_valid_i=1 -> accept same cycle, load_o next cycle.
- Mode change mid-block: accept encrypt, toggle decrypt_i every cycle -> shift_right_o stays 0, schedule unchanged.
- Reset at round 7 -> next cycle all outputs at reset values, in_ready_o=1, no fp_en_o; new request completes normally.
- NUM_ROUNDS=4: accept at 0 -> round_en_o cycles 2..5, fp_en_o cycle 6, out_valid_o cycle 7; strobe mutual exclusion asserted throughout all tests.
